// File: rtl/lane_enable_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lane_enable_ctrl_if
// Description : Per-lane write request handshake between requesters and the
//               lane enable controller. One valid/data/ready triple per lane.
//   req_valid  [LANES]  per-lane write request
//   req_data   [LANES]  per-lane write data bit
//   req_ready  [LANES]  per-lane accept (driven by the controller)
// Modports    : master (requester side), slave (controller side)
// Revision    : 1.0 - initial release
// ============================================================================
interface lane_enable_ctrl_if #(
  parameter int LANES = 5
);
  logic [LANES-1:0] req_valid;
  logic [LANES-1:0] req_data;
  logic [LANES-1:0] req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/lane_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lane_enable_ctrl
// Description : Upstream enable generator for a per-bit-enable output register
//               bank. Accepts per-lane writes, drives one-cycle enable pulses
//               with data, suppresses writes that would not change the bank,
//               and puts idle lanes to sleep with a fixed wake-up latency.
// Ports       :
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   req_if          slave  per-lane valid/data/ready handshake
//   i_cur_q         in   current bank output, fed back for change detection
//   i_force_wake    in   wakes every sleeping lane
//   o_en            out  registered per-lane enable to the bank
//   o_d_out         out  registered per-lane data to the bank
//   o_sleep         out  1 while the lane is asleep
//   o_suppress_cnt  out  (ACG_STATS_EN only) saturating suppressed-write count
//   o_sleep_cnt     out  (ACG_STATS_EN only) saturating ACTIVE->SLEEP count
// Options     : define ACG_STATS_EN to add the statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module lane_enable_ctrl #(
  parameter int LANES       = 5,
  parameter int IDLE_CYCLES = 8,   // 2..255
  parameter int WAKE_CYCLES = 2    // 1..15
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  lane_enable_ctrl_if.slave     req_if,
  input  wire logic [LANES-1:0] i_cur_q,
  input  wire logic             i_force_wake,
  output logic      [LANES-1:0] o_en,
  output logic      [LANES-1:0] o_d_out,
  output logic      [LANES-1:0] o_sleep
`ifdef ACG_STATS_EN
  ,
  output logic      [15:0]      o_suppress_cnt,
  output logic      [15:0]      o_sleep_cnt
`endif
);

  localparam logic [7:0] C_IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] C_WAKE_LAST = 4'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } lane_state_t;

  logic [LANES-1:0] w_ready;
  logic [LANES-1:0] w_eff;
  logic [LANES-1:0] w_to_sleep;
`ifdef ACG_STATS_EN
  logic [LANES-1:0] w_sup;
`endif

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_state_t r_state;
      logic [7:0]  r_idle;
      logic [3:0]  r_wake;
      logic        r_en;
      logic        r_d_out;
      logic        r_sleep;
      logic        w_acc;
      logic        w_ref;

      assign w_ready[g] = (r_state == ST_ACTIVE);
      assign w_acc      = req_if.req_valid[g] & w_ready[g];
      // The bank output lags an accepted write by two edges; while a pulse is
      // outstanding the value about to be written is the true reference.
      assign w_ref      = r_en ? r_d_out : i_cur_q[g];
      assign w_eff[g]   = w_acc & (req_if.req_data[g] != w_ref);
      // Threshold cycle without an effective write sends the lane to sleep;
      // an effective write on that same cycle takes priority.
      assign w_to_sleep[g] = w_ready[g] & ~w_eff[g] & (r_idle == C_IDLE_LAST);
`ifdef ACG_STATS_EN
      assign w_sup[g]   = w_acc & (req_if.req_data[g] == w_ref);
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_ACTIVE;
          r_idle  <= 8'd0;
          r_wake  <= 4'd0;
          r_en    <= 1'b0;
          r_d_out <= 1'b0;
          r_sleep <= 1'b0;
        end else begin
          r_en <= 1'b0;
          case (r_state)
            ST_ACTIVE: begin
              if (w_eff[g]) begin
                r_en    <= 1'b1;
                r_d_out <= req_if.req_data[g];
                r_idle  <= 8'd0;
              end else if (w_to_sleep[g]) begin
                r_state <= ST_SLEEP;
                r_sleep <= 1'b1;
                r_idle  <= 8'd0;
              end else begin
                r_idle  <= r_idle + 8'd1;
              end
            end
            ST_SLEEP: begin
              // The waking request is not accepted; the requester holds it.
              if (req_if.req_valid[g] || i_force_wake) begin
                r_state <= ST_WAKE;
                r_sleep <= 1'b0;
                r_wake  <= 4'd0;
              end
            end
            ST_WAKE: begin
              if (r_wake == C_WAKE_LAST) begin
                r_state <= ST_ACTIVE;
                r_idle  <= 8'd0;
              end else begin
                r_wake  <= r_wake + 4'd1;
              end
            end
            default: begin
              r_state <= ST_ACTIVE;
              r_sleep <= 1'b0;
              r_idle  <= 8'd0;
            end
          endcase
        end
      end

      assign o_en[g]    = r_en;
      assign o_d_out[g] = r_d_out;
      assign o_sleep[g] = r_sleep;
    end
  endgenerate

  assign req_if.req_ready = w_ready;

`ifdef ACG_STATS_EN
  function automatic logic [16:0] popcount(input logic [LANES-1:0] v);
    logic [16:0] s;
    s = 17'd0;
    for (int k = 0; k < LANES; k++) begin
      s = s + 17'(v[k]);
    end
    return s;
  endfunction

  logic [15:0] r_suppress_cnt;
  logic [15:0] r_sleep_cnt;
  logic [16:0] w_sup_sum;
  logic [16:0] w_slp_sum;

  // One extra bit of headroom catches the wrap so the count saturates.
  assign w_sup_sum = {1'b0, r_suppress_cnt} + popcount(w_sup);
  assign w_slp_sum = {1'b0, r_sleep_cnt} + popcount(w_to_sleep);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_suppress_cnt <= 16'd0;
      r_sleep_cnt    <= 16'd0;
    end else begin
      r_suppress_cnt <= w_sup_sum[16] ? 16'hFFFF : w_sup_sum[15:0];
      r_sleep_cnt    <= w_slp_sum[16] ? 16'hFFFF : w_slp_sum[15:0];
    end
  end

  assign o_suppress_cnt = r_suppress_cnt;
  assign o_sleep_cnt    = r_sleep_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/lane_enable_ctrl.md
Name: lane_enable_ctrl

Overview:
Upstream enable generator for the 5-lane per-bit-enable output register bank in the automatic clock gating design. Accepts per-lane write requests over valid/ready handshakes. Drives the bank's per-lane enable and data inputs, and suppresses any write whose data equals the bank's current value. Puts idle lanes to sleep after a programmable number of idle cycles, with a fixed wake-up latency.

Parameters:
LANES, 5, number of lanes; EN[i] drives the bank's En(i+1), D_OUT[i] drives D_IN[i].
IDLE_CYCLES, 8, consecutive idle cycles before a lane sleeps; legal range 2..255.
WAKE_CYCLES, 2, cycles spent in WAKE before a lane returns to ACTIVE; legal range 1..15.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
REQ_VALID  in  LANES  per-lane write request.
REQ_DATA  in  LANES  per-lane write data bit.
REQ_READY  out  LANES  per-lane accept; combinational from the lane state only.
CUR_Q  in  LANES  current bank output (OUT), fed back for change detection.
FORCE_WAKE  in  1  wakes all sleeping lanes.
EN  out  LANES  registered per-lane enable to the bank.
D_OUT  out  LANES  registered per-lane data to the bank.
SLEEP  out  LANES  1 while the lane is in SLEEP.

Behaviour:
- Reset (async assert, sync-to-CLK deassert handled externally):
  - every lane goes to ACTIVE with idle counter 0;
  - EN=0, D_OUT=0, SLEEP=0;
  - a reset arriving mid-WAKE or mid-write drops any pending EN pulse.
- Per-lane FSM, lanes fully independent:
  - ACTIVE: REQ_READY=1.
  - IDLE_CHK is not a separate state; it is the idle counter running inside ACTIVE.
  - SLEEP: REQ_READY=0, SLEEP=1.
  - WAKE: REQ_READY=0, SLEEP=0; wake counter runs 0..WAKE_CYCLES-1.
- Accept: REQ_VALID[i] & REQ_READY[i] at a rising edge.
  - Effective write (REQ_DATA[i] != CUR_Q[i]):
    - next cycle EN[i]=1 for exactly one cycle and D_OUT[i]=REQ_DATA[i];
    - the bank captures on the following edge, so OUT changes 2 edges after accept;
    - idle counter clears to 0.
  - Suppressed write (REQ_DATA[i] == CUR_Q[i]): accepted, EN[i] stays 0, D_OUT[i] unchanged, counts as an idle cycle.
- Back-to-back writes to the same lane:
  - CUR_Q lags by 2 cycles, so comparison uses D_OUT[i] instead of CUR_Q[i] whenever EN[i]=1 in the current cycle (pending write).
  - Each effective write produces its own 1-cycle EN pulse.
- Idle counting (ACTIVE only):
  - increments on every cycle without an effective write;
  - when it reaches IDLE_CYCLES-1 and the current cycle has no effective write, the lane enters SLEEP on the next edge;
  - an effective write on the threshold cycle wins: the counter clears and the lane stays ACTIVE.
- SLEEP -> WAKE: REQ_VALID[i]=1 or FORCE_WAKE=1; the request is not accepted and must be held by the requester.
- WAKE -> ACTIVE after WAKE_CYCLES cycles, with idle counter 0. The first acceptance can occur WAKE_CYCLES+1 edges after the wake trigger.
- FORCE_WAKE has no effect on lanes in ACTIVE or WAKE.
- D_OUT holds its last value at all times when EN=0. EN is never 1 while SLEEP=1.

Optional Feature:
ACG_STATS_EN:
- Defined:
  - adds output SUPPRESS_CNT (16 bits): total suppressed writes across all lanes, saturating at 0xFFFF, cleared by reset;
  - adds output SLEEP_CNT (16 bits): count of ACTIVE->SLEEP transitions across all lanes, saturating, cleared by reset;
  - when several lanes hit the same event in one cycle, each counter adds the number of lanes involved (popcount), then saturates.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset: RST_N low mid-run with EN[2] pending -> EN=0, D_OUT=0, SLEEP=0, REQ_READY=5'b11111 immediately, without waiting for a clock edge.
- Effective write: CUR_Q=0, lane 0 REQ_VALID=1, REQ_DATA=1 -> EN=5'b00001 for exactly 1 cycle the next cycle, D_OUT[0]=1; bank OUT[0]=1 two edges after accept.
- Suppression: CUR_Q[3]=1, write REQ_DATA[3]=1 -> accepted, EN[3] stays 0; with ACG_STATS_EN, SUPPRESS_CNT goes 0->1.
- Sleep timing: IDLE_CYCLES=8, lane 4 gets no effective writes for 8 cycles -> SLEEP[4]=1 after the 8th edge and REQ_READY[4]=0. An effective write on the 8th cycle instead -> SLEEP[4] stays 0, counter restarts.
- Wake: lane 1 asleep, REQ_VALID[1]=1 held, WAKE_CYCLES=2 -> REQ_READY[1]=1 on the 3rd edge after assertion; the write is then accepted and EN[1] pulses the following cycle.
- Back-to-back and force wake:
  - lane 2 writes 1,0 on consecutive cycles with CUR_Q=0 -> two EN[2] pulses, D_OUT[2]=1 then 0;
  - FORCE_WAKE with all lanes asleep -> all SLEEP=0 the next cycle, all REQ_READY=1 after 2 more cycles.
